// File: rtl/pwmdecoder_pkg.sv
// Shared definitions for the PWM decoder Wishbone arbiter and its helpers.
package pwmdecoder_pkg;

    // Arbiter ownership state: idle, or bus owned by master 0 / master 1
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Byte-address width of the decoder register window
    localparam int DEF_ADDR_WIDTH     = 6;

    // Default strobe watchdog limit in clock cycles
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/pwmdecoder_wb_watchdog.sv
// Per-access Wishbone watchdog: counts strobe cycles with no slave response and
// raises tmo_fire for one cycle when the wait reaches the configured limit.
module wb_watchdog
    import pwmdecoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMO_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,     // a master currently owns the port
    input  logic stb,        // owner's strobe
    input  logic resp,       // any slave ACK/ERR/RTY this cycle
    output logic tmo_fire
);

    localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT_CYCLES);

    if (TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_timeout
        $error("wb_watchdog: TIMEOUT_CYCLES does not fit in TMO_W bits");
    end

    logic [TMO_W-1:0] cnt;

    // A slave response always wins over the watchdog in the same cycle;
    // a limit of zero disables the watchdog entirely.
    assign tmo_fire = (TIMEOUT_CYCLES != 0) && active && stb && !resp && (cnt == LIMIT);

    // Count unanswered strobe cycles; any break in the wait restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!active || !stb || resp || tmo_fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TMO_W'(1);
        end
    end

endmodule

// File: rtl/pwmdecoder_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the PWM decoder register
// bank. The grant is held for the whole CYC and a watchdog ends hung strobes.
module pwmdecoder_wb_arbiter
    import pwmdecoder_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TMO_W          = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [SELECT_WIDTH-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    output logic                    m0_rty_o,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [SELECT_WIDTH-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    m1_rty_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic                    s_we_o,
    output logic [SELECT_WIDTH-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic [1:0]              grant_o,
    output logic                    tmo_o
);

    arb_state_t state;
    logic       last_owner;   // 0 = m0 was served last, 1 = m1
    logic       tmo_fire;
    logic       owner_stb;
    logic       slave_resp;

    assign slave_resp = s_ack_i | s_err_i | s_rty_i;
    assign owner_stb  = (state == OWN0) ? m0_stb_i :
                        (state == OWN1) ? m1_stb_i : 1'b0;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMO_W          (TMO_W)
    ) u_watchdog (
        .clk      (i_clk),
        .rst      (i_rst),
        .active   (state != IDLE),
        .stb      (owner_stb),
        .resp     (slave_resp),
        .tmo_fire (tmo_fire)
    );

    // Ownership FSM: round-robin on ties, grant held until the owner drops CYC,
    // and always one idle cycle between owners.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state <= last_owner ? OWN0 : OWN1;
                    end else if (m0_cyc_i) begin
                        state <= OWN0;
                    end else if (m1_cyc_i) begin
                        state <= OWN1;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state      <= IDLE;
                        last_owner <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state      <= IDLE;
                        last_owner <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the owner to the slave and the slave back to the owner only;
    // everything reads as zero while idle.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        grant_o  = 2'b00;
        tmo_o    = 1'b0;
        unique case (state)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i & ~tmo_fire;
                s_cyc_o  = m0_cyc_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_fire;
                m0_rty_o = s_rty_i;
                grant_o  = 2'b01;
                tmo_o    = tmo_fire;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i & ~tmo_fire;
                s_cyc_o  = m1_cyc_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_fire;
                m1_rty_o = s_rty_i;
                grant_o  = 2'b10;
                tmo_o    = tmo_fire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pwmdecoder_wb_arbiter.sv
// Randomized and directed bench for pwmdecoder_wb_arbiter against a behavioural
// model of ownership, round-robin fairness and the strobe watchdog.
module tb_pwmdecoder_wb_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  madr [2];
    logic [31:0] mdat [2];
    logic        mwe  [2];
    logic [3:0]  msel [2];
    logic        mstb [2];
    logic        mcyc [2];
    logic [31:0] mdo  [2];
    logic        mack [2];
    logic        merr [2];
    logic        mrty [2];
    logic [5:0]  s_adr;
    logic [31:0] s_dat_o, s_dat_i;
    logic        s_we, s_stb, s_cyc, s_ack, s_err, s_rty, tmo;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    int vectors = 0;
    int miscompares = 0;

    // reference model: owner index (-1 idle), last served master, wait count
    int  m_own, m_last, m_cnt;
    bit  m_init = 0;
    bit  e_fire;
    int  n_tmo = 0;

    always #5 clk = ~clk;

    pwmdecoder_wb_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .SELECT_WIDTH(4),
        .TIMEOUT_CYCLES(TMO), .TMO_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(mdo[0]), .m0_we_i(mwe[0]),
        .m0_sel_i(msel[0]), .m0_stb_i(mstb[0]), .m0_cyc_i(mcyc[0]),
        .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]),
        .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(mdo[1]), .m1_we_i(mwe[1]),
        .m1_sel_i(msel[1]), .m1_stb_i(mstb[1]), .m1_cyc_i(mcyc[1]),
        .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .tmo_o(tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs follow directly from who owns the bus this cycle
    task automatic check_outputs();
        logic [1:0]  e_grant;
        logic        e_scyc, e_sstb;
        logic [42:0] e_bus;
        logic [2:0]  e_fl [2];
        logic [31:0] e_do [2];
        bit          resp, stb;
        e_grant = 2'b00; e_scyc = 0; e_sstb = 0; e_bus = '0; e_fire = 0;
        for (int m = 0; m < 2; m++) begin
            e_fl[m] = 3'b000;
            e_do[m] = 32'h0;
        end
        if (m_own >= 0) begin
            stb    = mstb[m_own];
            resp   = s_ack | s_err | s_rty;
            e_fire = stb && !resp && (m_cnt == TMO);
            e_grant = (m_own == 0) ? 2'b01 : 2'b10;
            e_scyc = mcyc[m_own];
            e_sstb = stb && !e_fire;
            e_bus  = {madr[m_own], mdat[m_own], mwe[m_own], msel[m_own]};
            e_fl[m_own] = {s_ack, s_err | e_fire, s_rty};
            e_do[m_own] = s_dat_i;
        end
        if (!m_init) return;
        check("grant", 64'(grant), 64'(e_grant));
        check("s_cyc", 64'(s_cyc), 64'(e_scyc));
        check("s_stb", 64'(s_stb), 64'(e_sstb));
        check("tmo", 64'(tmo), 64'(e_fire));
        check("s_bus", 64'({s_adr, s_dat_o, s_we, s_sel}), 64'(e_bus));
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_flags", m), 64'({mack[m], merr[m], mrty[m]}), 64'(e_fl[m]));
            check($sformatf("m%0d_dat", m), 64'(mdo[m]), 64'(e_do[m]));
        end
        if (e_fire) n_tmo++;
    endtask

    task automatic update_model();
        bit resp;
        resp = s_ack | s_err | s_rty;
        if (rst) begin
            m_own = -1; m_last = 1; m_cnt = 0; m_init = 1;
        end else if (m_own < 0) begin
            m_cnt = 0;
            if (mcyc[0] && mcyc[1]) m_own = 1 - m_last;
            else if (mcyc[0])       m_own = 0;
            else if (mcyc[1])       m_own = 1;
        end else begin
            m_cnt = (mstb[m_own] && !resp && !e_fire) ? m_cnt + 1 : 0;
            if (!mcyc[m_own]) begin
                m_last = m_own;
                m_own  = -1;
            end
        end
    endtask

    // one clock: compare at the falling edge, advance the model at the rising edge
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic master(input int m, input bit cyc, input bit stb);
        mcyc[m] = cyc;
        mstb[m] = stb;
        madr[m] = 6'($urandom);
        mdat[m] = $urandom;
        mwe[m]  = 1'($urandom);
        msel[m] = 4'($urandom);
    endtask

    task automatic slave(input bit ack, input bit err, input bit rty);
        s_ack = ack; s_err = err; s_rty = rty;
        s_dat_i = $urandom;
    endtask

    initial begin
        rst = 1;
        master(0, 0, 0); master(1, 0, 0); slave(0, 0, 0);
        m_own = -1; m_last = 1; m_cnt = 0;
        tick();
        rst = 0;
        tick();

        // m0 single read at 0x04, slave answers on the third strobe cycle
        master(0, 1, 1); madr[0] = 6'h04; mwe[0] = 0;
        tick(); tick(); tick();
        slave(1, 0, 0); s_dat_i = 32'h11221144;
        tick();
        slave(0, 0, 0); master(0, 0, 0);
        tick(); tick();

        // simultaneous requests: one read each, alternating owners
        for (int r = 0; r < 4; r++) begin
            master(0, 1, 1); master(1, 1, 1);
            tick();
            slave(1, 0, 0); tick();
            slave(0, 0, 0);
            if (m_own >= 0) master(m_own, 0, 0);
            tick();
            slave(1, 0, 0); tick();
            slave(0, 0, 0); master(0, 0, 0); master(1, 0, 0);
            tick();
        end

        // m1 holds CYC over three strobes while m0 waits
        master(1, 1, 1); tick();
        master(0, 1, 1);
        for (int b = 0; b < 3; b++) begin
            slave(0, 0, 0); tick();
            slave(1, 0, 0); tick();
        end
        slave(0, 0, 0); master(1, 0, 0); tick(); tick(); tick();
        master(0, 0, 0); tick();

        // unanswered m0 strobe runs into the watchdog, then m1 served
        master(0, 1, 1);
        for (int c = 0; c < 9; c++) tick();
        master(0, 0, 0); tick();
        master(1, 1, 1); tick(); tick();
        slave(1, 0, 0); tick();
        slave(0, 0, 0); master(1, 0, 0); tick(); tick();

        // slave acks exactly on the watchdog limit cycle
        master(0, 1, 1); tick();
        for (int c = 0; c < TMO; c++) tick();
        slave(1, 0, 0); tick();
        slave(0, 0, 0); master(0, 0, 0); tick(); tick();

        // reset lands during an m1 write
        master(1, 1, 1); mwe[1] = 1; tick(); tick();
        rst = 1; tick();
        rst = 0; tick();
        master(0, 1, 1); master(1, 1, 1); tick(); tick();
        master(0, 0, 0); master(1, 0, 0); tick(); tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            rst = ($urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                if (mcyc[m]) begin
                    if ($urandom_range(0, 5) == 0) master(m, 0, 0);
                    else                           master(m, 1, $urandom_range(0, 4) != 0);
                end else if ($urandom_range(0, 3) == 0) begin
                    master(m, 1, $urandom_range(0, 4) != 0);
                end else begin
                    master(m, 0, 0);
                end
            end
            r = $urandom_range(0, 99);
            slave(r < 10, r >= 10 && r < 13, r >= 13 && r < 15);
            tick();
        end

        check("watchdog_seen", 64'(n_tmo > 0), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
